// File: rtl/rf_pkg.sv
// Shared defaults and word types for the multi-port register file.
// No logic of its own; widths derive from NREG_DEF and DATA_W_DEF.
// No flow control: constants, types and a width helper only.
package rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NREG_DEF   = 32;

  // Address width for a file of nreg entries (at least one bit).
  function automatic int addr_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  localparam int ADDR_W_DEF = addr_w(NREG_DEF);

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] data_word_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: one busy bit per register, set on allocate, cleared by writeback.
// Lookups are combinational; set/clear take effect after the next rising clk.
// No backpressure: the issue stage stalls itself on a busy source. Build option RF_BYPASS_EN.
module rf_scoreboard import rf_pkg::*; #(
  parameter  int NREG   = NREG_DEF,
  parameter  int NUM_RD = 2,
  parameter  int NUM_WR = 2,
  localparam int ADDR_W = addr_w(NREG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_vld,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic [NUM_WR-1:0]        wb_vld,
  input  logic [NUM_WR*ADDR_W-1:0] wb_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;

  // Next busy state: writebacks clear, a same-cycle allocate re-sets (new producer), reg 0 pinned to 0.
  always_comb begin
    busy_nxt = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wb_vld[w]) busy_nxt[wb_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (alloc_vld) busy_nxt[alloc_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Busy register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_nxt;
  end

  // Per-read-port busy lookup; with bypass a same-cycle writeback hides the busy bit unless re-allocated.
  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_busy[p] = busy_q[rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef RF_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) begin
        if (wb_vld[w] && wb_addr[w*ADDR_W +: ADDR_W] == rd_addr[p*ADDR_W +: ADDR_W] &&
            !(alloc_vld && alloc_addr == rd_addr[p*ADDR_W +: ADDR_W]))
          rd_busy[p] = 1'b0;
      end
`endif
      if (rd_addr[p*ADDR_W +: ADDR_W] == '0) rd_busy[p] = 1'b0;
    end
  end

endmodule

// File: rtl/rf_mp.sv
// Multi-port integer register file with busy scoreboard; reg 0 reads as zero. Build option RF_BYPASS_EN.
// Reads 0-cycle combinational; writes land on the rising clk (bypass forwards them same cycle).
// No backpressure: every writeback is accepted; same-address collisions resolve to the highest port.
module rf_mp import rf_pkg::*; #(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int NREG   = NREG_DEF,
  parameter  int NUM_RD = 2,
  parameter  int NUM_WR = 2,
  localparam int ADDR_W = addr_w(NREG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] idu_rf_src_addr,
  output logic [NUM_RD*DATA_W-1:0] rf_idu_src_data,
  output logic [NUM_RD-1:0]        rf_idu_src_busy,
  input  logic                     idu_rf_alloc_vld,
  input  logic [ADDR_W-1:0]        idu_rf_alloc_addr,
  input  logic [NUM_WR-1:0]        wb_rf_vld,
  input  logic [NUM_WR*ADDR_W-1:0] wb_rf_addr,
  input  logic [NUM_WR*DATA_W-1:0] wb_rf_data
);

  logic [DATA_W-1:0] regs [NREG];

  // Storage write: ports applied in index order so the highest-index port wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wb_rf_vld[w] && wb_rf_addr[w*ADDR_W +: ADDR_W] != '0)
          regs[wb_rf_addr[w*ADDR_W +: ADDR_W]] <= wb_rf_data[w*DATA_W +: DATA_W];
      end
    end
  end

  // Read muxes: registered value, optionally overridden by the highest matching same-cycle writeback.
  always_comb begin
    rf_idu_src_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (idu_rf_src_addr[p*ADDR_W +: ADDR_W] != '0) begin
        rf_idu_src_data[p*DATA_W +: DATA_W] = regs[idu_rf_src_addr[p*ADDR_W +: ADDR_W]];
`ifdef RF_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++) begin
          if (wb_rf_vld[w] && wb_rf_addr[w*ADDR_W +: ADDR_W] == idu_rf_src_addr[p*ADDR_W +: ADDR_W])
            rf_idu_src_data[p*DATA_W +: DATA_W] = wb_rf_data[w*DATA_W +: DATA_W];
        end
`endif
      end
    end
  end

  rf_scoreboard #(
    .NREG   (NREG),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .alloc_vld  (idu_rf_alloc_vld),
    .alloc_addr (idu_rf_alloc_addr),
    .wb_vld     (wb_rf_vld),
    .wb_addr    (wb_rf_addr),
    .rd_addr    (idu_rf_src_addr),
    .rd_busy    (rf_idu_src_busy)
  );

endmodule
